// File: rtl/demux_1x2_reg_pkg.sv
// Shared constants, select encodings and slot types for the registered 1-to-2 demultiplexer.
package demux_1x2_reg_pkg;

   localparam int unsigned M_DEFAULT     = 23;
   localparam int unsigned CNT_W_DEFAULT = 16;

   localparam logic SEL_OUT0 = 1'b0;
   localparam logic SEL_OUT1 = 1'b1;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Per-cycle events seen by one holding slot.
   typedef struct packed {
      logic flush;
      logic load;
      logic deliver;
   } slot_ctl_t;

endpackage : demux_1x2_reg_pkg

// File: rtl/demux_slot_reg.sv
// One-entry holding register with valid/ready output, synchronous flush and a
// saturating count of delivered words.
module demux_slot_reg
   import demux_1x2_reg_pkg::*;
#(
   parameter int unsigned M     = M_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic [M-1:0]     d_in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [M-1:0]     d_out,
   output logic [CNT_W-1:0] cnt,
   output logic             slot_ready_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   slot_state_e      state_q, state_d;
   logic [M-1:0]     data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   slot_ctl_t        ctl_c;

   always_comb begin
      ctl_c         = '0;
      ctl_c.flush   = flush;
      ctl_c.load    = load & ~flush;
      ctl_c.deliver = (state_q == SLOT_FULL) & out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush wins over everything; a delivery without a reload empties the slot.
   always_comb begin
      state_d = state_q;
      if (ctl_c.flush) begin
         state_d = SLOT_EMPTY;
      end else begin
         case (state_q)
            SLOT_EMPTY: begin
               if (ctl_c.load) state_d = SLOT_FULL;
            end
            SLOT_FULL: begin
               if (ctl_c.load)         state_d = SLOT_FULL;
               else if (ctl_c.deliver) state_d = SLOT_EMPTY;
            end
            default: state_d = SLOT_EMPTY;
         endcase
      end
   end

   // Data holds unless reloaded; counter saturates rather than wrapping.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (ctl_c.load) begin
         data_d = d_in;
      end
      if (ctl_c.deliver && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_valid    = (state_q == SLOT_FULL);
   assign d_out        = data_q;
   assign cnt          = cnt_q;
   assign slot_ready_c = (state_q == SLOT_EMPTY) | out_ready;

endmodule : demux_slot_reg

// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted word to one of two
// holding slots selected by MS, with independent valid/ready on each output.
module demux_1x2_reg
   import demux_1x2_reg_pkg::*;
#(
   parameter int unsigned M     = M_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             MS,
   input  logic [M-1:0]     D_in,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [M-1:0]     D_out0,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [M-1:0]     D_out1,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic sel_out1_c;
   logic slot0_ready_c;
   logic slot1_ready_c;
   logic accept_c;
   logic load0_c;
   logic load1_c;

   // Ready follows only the slot the current word targets.
   always_comb begin
      sel_out1_c = (MS == SEL_OUT1);
      in_ready   = ~flush & (sel_out1_c ? slot1_ready_c : slot0_ready_c);
      accept_c   = in_valid & in_ready;
      load0_c    = accept_c & ~sel_out1_c;
      load1_c    = accept_c &  sel_out1_c;
   end

   demux_slot_reg #(
      .M     (M),
      .CNT_W (CNT_W)
   ) u_slot0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .load         (load0_c),
      .d_in         (D_in),
      .out_ready    (out0_ready),
      .out_valid    (out0_valid),
      .d_out        (D_out0),
      .cnt          (cnt0),
      .slot_ready_c (slot0_ready_c)
   );

   demux_slot_reg #(
      .M     (M),
      .CNT_W (CNT_W)
   ) u_slot1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .load         (load1_c),
      .d_in         (D_in),
      .out_ready    (out1_ready),
      .out_valid    (out1_valid),
      .d_out        (D_out1),
      .cnt          (cnt1),
      .slot_ready_c (slot1_ready_c)
   );

   // The selector must be a known value whenever a word is offered.
   a_ms_known : assert property (@(posedge clk) disable iff (!rst_n)
      in_valid |-> !$isunknown(MS));

endmodule : demux_1x2_reg

// File: tb/tb_demux_1x2_reg.sv
// Directed self-checking bench for demux_1x2_reg, with a second instance at
// CNT_W=4 sharing the same stimulus to exercise counter saturation.
module tb_demux_1x2_reg;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        MS;
   logic [22:0] D_in;
   logic        out0_ready;
   logic        out1_ready;

   logic        in_ready;
   logic        out0_valid;
   logic [22:0] D_out0;
   logic        out1_valid;
   logic [22:0] D_out1;
   logic [15:0] cnt0;
   logic [15:0] cnt1;

   logic        s_in_ready;
   logic        s_out0_valid;
   logic [22:0] s_D_out0;
   logic        s_out1_valid;
   logic [22:0] s_D_out1;
   logic [3:0]  s_cnt0;
   logic [3:0]  s_cnt1;

   int pass_cnt;
   int total_cnt;

   demux_1x2_reg #(.M(23), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .MS(MS), .D_in(D_in),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .D_out0(D_out0),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .D_out1(D_out1),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   demux_1x2_reg #(.M(23), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(s_in_ready), .MS(MS), .D_in(D_in),
      .out0_valid(s_out0_valid), .out0_ready(out0_ready), .D_out0(s_D_out0),
      .out1_valid(s_out1_valid), .out1_ready(out1_ready), .D_out1(s_D_out1),
      .cnt0(s_cnt0), .cnt1(s_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; MS = 1'b0; D_in = '0;
      out0_ready = 1'b0; out1_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++; if (out0_valid !== 1'b0) $display("FAIL reset_out0_valid got %b exp 0", out0_valid); else pass_cnt++;
      total_cnt++; if (out1_valid !== 1'b0) $display("FAIL reset_out1_valid got %b exp 0", out1_valid); else pass_cnt++;
      total_cnt++; if (D_out0 !== 23'h0) $display("FAIL reset_D_out0 got %h exp 0", D_out0); else pass_cnt++;
      total_cnt++; if (D_out1 !== 23'h0) $display("FAIL reset_D_out1 got %h exp 0", D_out1); else pass_cnt++;
      total_cnt++; if (cnt0 !== 16'd0) $display("FAIL reset_cnt0 got %0d exp 0", cnt0); else pass_cnt++;
      total_cnt++; if (cnt1 !== 16'd0) $display("FAIL reset_cnt1 got %0d exp 0", cnt1); else pass_cnt++;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_route();
      MS = 1'b0; D_in = 23'h2AAAAA; in_valid = 1'b1; out0_ready = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL route_in_ready got %b exp 1", in_ready); else pass_cnt++;
      step();
      in_valid = 1'b0;
      total_cnt++; if (out0_valid !== 1'b1) $display("FAIL route_out0_valid got %b exp 1", out0_valid); else pass_cnt++;
      total_cnt++; if (D_out0 !== 23'h2AAAAA) $display("FAIL route_D_out0 got %h exp 2aaaaa", D_out0); else pass_cnt++;
      total_cnt++; if (out1_valid !== 1'b0) $display("FAIL route_out1_valid got %b exp 0", out1_valid); else pass_cnt++;
      total_cnt++; if (cnt0 !== 16'd0) $display("FAIL route_cnt0_pre got %0d exp 0", cnt0); else pass_cnt++;
      step();
      total_cnt++; if (cnt0 !== 16'd1) $display("FAIL route_cnt0_post got %0d exp 1", cnt0); else pass_cnt++;
      total_cnt++; if (out0_valid !== 1'b0) $display("FAIL route_out0_drained got %b exp 0", out0_valid); else pass_cnt++;
      total_cnt++; if (D_out0 !== 23'h2AAAAA) $display("FAIL route_D_out0_hold got %h exp 2aaaaa", D_out0); else pass_cnt++;
      out0_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [22:0] w;
      MS = 1'b1; out1_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         w = 23'h100000 + 23'(i * 23'h111);
         D_in = w;
         #1;
         total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); else pass_cnt++;
         step();
         total_cnt++; if (out1_valid !== 1'b1) $display("FAIL stream_out1_valid[%0d] got %b exp 1", i, out1_valid); else pass_cnt++;
         total_cnt++; if (D_out1 !== w) $display("FAIL stream_D_out1[%0d] got %h exp %h", i, D_out1, w); else pass_cnt++;
      end
      in_valid = 1'b0;
      total_cnt++; if (cnt1 !== 16'd7) $display("FAIL stream_cnt1_pre got %0d exp 7", cnt1); else pass_cnt++;
      step();
      total_cnt++; if (cnt1 !== 16'd8) $display("FAIL stream_cnt1 got %0d exp 8", cnt1); else pass_cnt++;
      total_cnt++; if (out1_valid !== 1'b0) $display("FAIL stream_out1_drained got %b exp 0", out1_valid); else pass_cnt++;
      total_cnt++; if (cnt0 !== 16'd1) $display("FAIL stream_cnt0_untouched got %0d exp 1", cnt0); else pass_cnt++;
      out1_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      out0_ready = 1'b0; out1_ready = 1'b0;
      MS = 1'b0; D_in = 23'h012345; in_valid = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_first_in_ready got %b exp 1", in_ready); else pass_cnt++;
      step();
      D_in = 23'h6789AB;
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_stall_in_ready got %b exp 0", in_ready); else pass_cnt++;
      step();
      total_cnt++; if (D_out0 !== 23'h012345) $display("FAIL bp_D_out0_stable got %h exp 012345", D_out0); else pass_cnt++;
      total_cnt++; if (out0_valid !== 1'b1) $display("FAIL bp_out0_valid got %b exp 1", out0_valid); else pass_cnt++;
      MS = 1'b1; D_in = 23'h55AA55;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_other_in_ready got %b exp 1", in_ready); else pass_cnt++;
      step();
      in_valid = 1'b0;
      total_cnt++; if (out1_valid !== 1'b1) $display("FAIL bp_out1_valid got %b exp 1", out1_valid); else pass_cnt++;
      total_cnt++; if (D_out1 !== 23'h55AA55) $display("FAIL bp_D_out1 got %h exp 55aa55", D_out1); else pass_cnt++;
      total_cnt++; if (D_out0 !== 23'h012345) $display("FAIL bp_D_out0_still got %h exp 012345", D_out0); else pass_cnt++;
   endtask

   task automatic test_flush();
      flush = 1'b1; out1_ready = 1'b1; in_valid = 1'b1; MS = 1'b1; D_in = 23'h7FFFFF;
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b exp 0", in_ready); else pass_cnt++;
      step();
      flush = 1'b0; in_valid = 1'b0; out1_ready = 1'b0;
      total_cnt++; if (out0_valid !== 1'b0) $display("FAIL flush_out0_valid got %b exp 0", out0_valid); else pass_cnt++;
      total_cnt++; if (out1_valid !== 1'b0) $display("FAIL flush_out1_valid got %b exp 0", out1_valid); else pass_cnt++;
      total_cnt++; if (cnt1 !== 16'd9) $display("FAIL flush_cnt1 got %0d exp 9", cnt1); else pass_cnt++;
      total_cnt++; if (cnt0 !== 16'd1) $display("FAIL flush_cnt0 got %0d exp 1", cnt0); else pass_cnt++;
      total_cnt++; if (D_out1 !== 23'h55AA55) $display("FAIL flush_D_out1_hold got %h exp 55aa55", D_out1); else pass_cnt++;
      total_cnt++; if (D_out0 !== 23'h012345) $display("FAIL flush_D_out0_hold got %h exp 012345", D_out0); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      MS = 1'b1; D_in = 23'h3C3C3C; in_valid = 1'b1; out1_ready = 1'b0;
      step();
      in_valid = 1'b0;
      total_cnt++; if (out1_valid !== 1'b1) $display("FAIL rmid_out1_loaded got %b exp 1", out1_valid); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++; if (out1_valid !== 1'b0) $display("FAIL rmid_out1_valid got %b exp 0", out1_valid); else pass_cnt++;
      total_cnt++; if (D_out1 !== 23'h0) $display("FAIL rmid_D_out1 got %h exp 0", D_out1); else pass_cnt++;
      total_cnt++; if (D_out0 !== 23'h0) $display("FAIL rmid_D_out0 got %h exp 0", D_out0); else pass_cnt++;
      total_cnt++; if (cnt0 !== 16'd0) $display("FAIL rmid_cnt0 got %0d exp 0", cnt0); else pass_cnt++;
      total_cnt++; if (cnt1 !== 16'd0) $display("FAIL rmid_cnt1 got %0d exp 0", cnt1); else pass_cnt++;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_saturation();
      MS = 1'b0; out0_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         D_in = 23'(i);
         step();
         if (i == 15) begin
            total_cnt++; if (s_cnt0 !== 4'd15) $display("FAIL sat_cnt0_at15 got %0d exp 15", s_cnt0); else pass_cnt++;
         end
      end
      in_valid = 1'b0;
      step();
      total_cnt++; if (cnt0 !== 16'd20) $display("FAIL sat_wide_cnt0 got %0d exp 20", cnt0); else pass_cnt++;
      total_cnt++; if (s_cnt0 !== 4'd15) $display("FAIL sat_cnt0 got %0d exp 15", s_cnt0); else pass_cnt++;
      total_cnt++; if (D_out0 !== 23'd19) $display("FAIL sat_last_word got %h exp 13", D_out0); else pass_cnt++;
      step();
      total_cnt++; if (s_cnt0 !== 4'd15) $display("FAIL sat_cnt0_held got %0d exp 15", s_cnt0); else pass_cnt++;
      out0_ready = 1'b0;
   endtask

   task automatic test_dual_delivery();
      out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
      MS = 1'b0; D_in = 23'h000AAA;
      step();
      MS = 1'b1; D_in = 23'h000BBB;
      step();
      in_valid = 1'b0;
      total_cnt++; if ({out0_valid, out1_valid} !== 2'b11) $display("FAIL dual_both_full got %b exp 11", {out0_valid, out1_valid}); else pass_cnt++;
      out0_ready = 1'b1; out1_ready = 1'b1;
      step();
      out0_ready = 1'b0; out1_ready = 1'b0;
      total_cnt++; if ({out0_valid, out1_valid} !== 2'b00) $display("FAIL dual_both_empty got %b exp 00", {out0_valid, out1_valid}); else pass_cnt++;
      total_cnt++; if (cnt0 !== 16'd21) $display("FAIL dual_cnt0 got %0d exp 21", cnt0); else pass_cnt++;
      total_cnt++; if (cnt1 !== 16'd1) $display("FAIL dual_cnt1 got %0d exp 1", cnt1); else pass_cnt++;
      total_cnt++; if (s_cnt1 !== 4'd1) $display("FAIL dual_sat_cnt1 got %0d exp 1", s_cnt1); else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_route();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_saturation();
      test_dual_delivery();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_demux_1x2_reg
